// File: rtl/marker_centroid_tracker.sv
// Marker centroid tracker: builds per-frame pixel count and x/y sums for five
// colour-masked markers. At frame end it snapshots the totals, runs one shared
// restoring divider to get centroids, maps blob area to depth, and publishes
// all coordinates together with a single-cycle valid pulse.
module marker_centroid_tracker #(
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned AREA_SHIFT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [4:0]  mask_in,
    input  logic        frame_end_in,
    output logic [11:0] hand_x_left_bottom,
    output logic [11:0] hand_x_left_top,
    output logic [11:0] hand_x_right_bottom,
    output logic [11:0] hand_x_right_top,
    output logic [11:0] head_x,
    output logic [11:0] hand_y_left_bottom,
    output logic [11:0] hand_y_left_top,
    output logic [11:0] hand_y_right_bottom,
    output logic [11:0] hand_y_right_top,
    output logic [11:0] head_y,
    output logic [13:0] hand_z_left_bottom,
    output logic [13:0] hand_z_left_top,
    output logic [13:0] hand_z_right_bottom,
    output logic [13:0] hand_z_right_top,
    output logic [13:0] head_z,
    output logic [4:0]  lost_out,
    output logic        coords_valid_out,
    output logic        busy_out,
    output logic        overrun_out
);

    localparam int unsigned NUM_MARKERS = 5;
    localparam int unsigned CNT_W       = 20;
    localparam int unsigned SUM_W       = 32;
    localparam int unsigned SUMX_W      = SUM_W + 1;
    localparam int unsigned TRIAL_W     = CNT_W + 1;
    localparam int unsigned COORD_W     = 12;
    localparam int unsigned Z_W         = 14;
    localparam int unsigned NUM_DIV     = 10;
    localparam int unsigned DIV_ITERS   = 32;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned CYC_W       = 6;
    localparam int unsigned MKR_W       = 3;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [Z_W-1:0]     Z_FAR     = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Live accumulators and their post-add values for this cycle
    logic [CNT_W-1:0]  cnt     [NUM_MARKERS];
    logic [SUM_W-1:0]  sx      [NUM_MARKERS];
    logic [SUM_W-1:0]  sy      [NUM_MARKERS];
    logic [CNT_W-1:0]  cnt_add [NUM_MARKERS];
    logic [SUM_W-1:0]  sx_add  [NUM_MARKERS];
    logic [SUM_W-1:0]  sy_add  [NUM_MARKERS];
    logic [SUMX_W-1:0] sx_sum  [NUM_MARKERS];
    logic [SUMX_W-1:0] sy_sum  [NUM_MARKERS];

    // Frame snapshot consumed by the divider
    logic [CNT_W-1:0]  snap_cnt [NUM_MARKERS];
    logic [SUM_W-1:0]  snap_sx  [NUM_MARKERS];
    logic [SUM_W-1:0]  snap_sy  [NUM_MARKERS];

    // Shared divider state
    logic [IDX_W-1:0]   div_idx;
    logic [CYC_W-1:0]   div_cyc;
    logic [CNT_W-1:0]   rem;
    logic [SUM_W-1:0]   quo;
    logic [MKR_W-1:0]   div_marker;
    logic [CNT_W-1:0]   divisor;
    logic [SUM_W-1:0]   dividend;
    logic [TRIAL_W-1:0] trial;
    logic               trial_ge;
    logic [CNT_W-1:0]   rem_next;
    logic [SUM_W-1:0]   quo_next;
    logic               last_div;
    logic [COORD_W-1:0] res   [NUM_DIV-1];
    logic [COORD_W-1:0] pub_q [NUM_DIV];

    // Published coordinate registers
    logic [COORD_W-1:0] x_q [NUM_MARKERS];
    logic [COORD_W-1:0] y_q [NUM_MARKERS];
    logic [Z_W-1:0]     z_q [NUM_MARKERS];

    function automatic logic [COORD_W-1:0] sat_coord(input logic [SUM_W-1:0] q);
        if (q > SUM_W'(COORD_MAX)) begin
            return COORD_MAX;
        end
        return q[COORD_W-1:0];
    endfunction

    // Larger blobs are nearer, so depth falls as area grows
    function automatic logic [Z_W-1:0] depth(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] area;
        area = c >> AREA_SHIFT;
        if (area >= CNT_W'(Z_FAR)) begin
            return '0;
        end
        return Z_FAR - area[Z_W-1:0];
    endfunction

    // Saturating per-marker add of the current pixel
    always_comb begin
        for (int i = 0; i < NUM_MARKERS; i++) begin
            sx_sum[i]  = {1'b0, sx[i]} + SUMX_W'(hcount_in);
            sy_sum[i]  = {1'b0, sy[i]} + SUMX_W'(vcount_in);
            cnt_add[i] = cnt[i];
            sx_add[i]  = sx[i];
            sy_add[i]  = sy[i];
            if (valid_in && mask_in[i]) begin
                cnt_add[i] = (cnt[i] == CNT_MAX) ? CNT_MAX : cnt[i] + CNT_W'(1);
                sx_add[i]  = sx_sum[i][SUM_W] ? '1 : sx_sum[i][SUM_W-1:0];
                sy_add[i]  = sy_sum[i][SUM_W] ? '1 : sy_sum[i][SUM_W-1:0];
            end
        end
    end

    // Accumulators run every cycle and restart at each frame end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_MARKERS; i++) begin
                cnt[i] <= '0;
                sx[i]  <= '0;
                sy[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MARKERS; i++) begin
                if (frame_end_in) begin
                    cnt[i] <= '0;
                    sx[i]  <= '0;
                    sy[i]  <= '0;
                end else begin
                    cnt[i] <= cnt_add[i];
                    sx[i]  <= sx_add[i];
                    sy[i]  <= sy_add[i];
                end
            end
        end
    end

    // Snapshot is only taken when the divider is free; otherwise the frame is dropped
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_MARKERS; i++) begin
                snap_cnt[i] <= '0;
                snap_sx[i]  <= '0;
                snap_sy[i]  <= '0;
            end
        end else if (frame_end_in && (state == IDLE)) begin
            for (int i = 0; i < NUM_MARKERS; i++) begin
                snap_cnt[i] <= cnt_add[i];
                snap_sx[i]  <= sx_add[i];
                snap_sy[i]  <= sy_add[i];
            end
        end
    end

    // One restoring-division step on the current operand pair
    always_comb begin
        div_marker = div_idx[IDX_W-1:1];
        divisor    = snap_cnt[div_marker];
        dividend   = div_idx[0] ? snap_sy[div_marker] : snap_sx[div_marker];
        trial      = {rem, quo[SUM_W-1]};
        trial_ge   = (trial >= {1'b0, divisor});
        rem_next   = trial_ge ? CNT_W'(trial - {1'b0, divisor}) : trial[CNT_W-1:0];
        quo_next   = {quo[SUM_W-2:0], trial_ge};
        last_div   = (state == DIVIDE) &&
                     (div_idx == IDX_W'(NUM_DIV - 1)) &&
                     (div_cyc == CYC_W'(DIV_ITERS));
    end

    // Final quotient goes straight to the publish path without an extra cycle
    always_comb begin
        for (int k = 0; k < NUM_DIV - 1; k++) begin
            pub_q[k] = res[k];
        end
        pub_q[NUM_DIV-1] = sat_coord(quo_next);
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_end_in) state_next = DIVIDE;
            DIVIDE:  if (last_div) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divider sequencing: 1 load cycle + 32 iterations per division, 10 divisions
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_idx <= '0;
            div_cyc <= '0;
            rem     <= '0;
            quo     <= '0;
            for (int k = 0; k < NUM_DIV - 1; k++) begin
                res[k] <= '0;
            end
        end else if (state != DIVIDE) begin
            div_idx <= '0;
            div_cyc <= '0;
        end else if (div_cyc == '0) begin
            rem     <= '0;
            quo     <= dividend;
            div_cyc <= CYC_W'(1);
        end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (div_cyc == CYC_W'(DIV_ITERS)) begin
                div_cyc <= '0;
                if (div_idx == IDX_W'(NUM_DIV - 1)) begin
                    div_idx <= '0;
                end else begin
                    res[div_idx] <= sat_coord(quo_next);
                    div_idx      <= div_idx + IDX_W'(1);
                end
            end else begin
                div_cyc <= div_cyc + CYC_W'(1);
            end
        end
    end

    // Outputs and status pulses; coordinates update atomically on entry to PUBLISH
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_MARKERS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= Z_FAR;
            end
            lost_out         <= '1;
            coords_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            coords_valid_out <= (state_next == PUBLISH);
            busy_out         <= (state_next == DIVIDE);
            overrun_out      <= frame_end_in && (state != IDLE);
            if (last_div) begin
                for (int i = 0; i < NUM_MARKERS; i++) begin
                    lost_out[i] <= (snap_cnt[i] < CNT_W'(MIN_PIXELS));
                    if (snap_cnt[i] >= CNT_W'(MIN_PIXELS)) begin
                        x_q[i] <= pub_q[2*i];
                        y_q[i] <= pub_q[2*i+1];
                        z_q[i] <= depth(snap_cnt[i]);
                    end
                end
            end
        end
    end

    assign hand_x_left_bottom  = x_q[0];
    assign hand_x_left_top     = x_q[1];
    assign hand_x_right_bottom = x_q[2];
    assign hand_x_right_top    = x_q[3];
    assign head_x              = x_q[4];
    assign hand_y_left_bottom  = y_q[0];
    assign hand_y_left_top     = y_q[1];
    assign hand_y_right_bottom = y_q[2];
    assign hand_y_right_top    = y_q[3];
    assign head_y              = y_q[4];
    assign hand_z_left_bottom  = z_q[0];
    assign hand_z_left_top     = z_q[1];
    assign hand_z_right_bottom = z_q[2];
    assign hand_z_right_top    = z_q[3];
    assign head_z              = z_q[4];

endmodule

// File: tb/tb_marker_centroid_tracker.sv
// Directed bench for marker_centroid_tracker: frame vectors with hand-computed
// centroids/depths, plus sequences for overrun, publish-cycle frame end and
// reset during division.
module tb_marker_centroid_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [4:0]  mask_in;
    logic        frame_end_in;
    logic [11:0] hand_x_left_bottom, hand_x_left_top, hand_x_right_bottom, hand_x_right_top, head_x;
    logic [11:0] hand_y_left_bottom, hand_y_left_top, hand_y_right_bottom, hand_y_right_top, head_y;
    logic [13:0] hand_z_left_bottom, hand_z_left_top, hand_z_right_bottom, hand_z_right_top, head_z;
    logic [4:0]  lost_out;
    logic        coords_valid_out;
    logic        busy_out;
    logic        overrun_out;

    marker_centroid_tracker dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .mask_in(mask_in),
        .frame_end_in(frame_end_in),
        .hand_x_left_bottom(hand_x_left_bottom), .hand_x_left_top(hand_x_left_top),
        .hand_x_right_bottom(hand_x_right_bottom), .hand_x_right_top(hand_x_right_top),
        .head_x(head_x),
        .hand_y_left_bottom(hand_y_left_bottom), .hand_y_left_top(hand_y_left_top),
        .hand_y_right_bottom(hand_y_right_bottom), .hand_y_right_top(hand_y_right_top),
        .head_y(head_y),
        .hand_z_left_bottom(hand_z_left_bottom), .hand_z_left_top(hand_z_left_top),
        .hand_z_right_bottom(hand_z_right_bottom), .hand_z_right_top(hand_z_right_top),
        .head_z(head_z),
        .lost_out(lost_out), .coords_valid_out(coords_valid_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    logic [11:0] ox [5];
    logic [11:0] oy [5];
    logic [13:0] oz [5];
    assign ox[0] = hand_x_left_bottom;  assign oy[0] = hand_y_left_bottom;  assign oz[0] = hand_z_left_bottom;
    assign ox[1] = hand_x_left_top;     assign oy[1] = hand_y_left_top;     assign oz[1] = hand_z_left_top;
    assign ox[2] = hand_x_right_bottom; assign oy[2] = hand_y_right_bottom; assign oz[2] = hand_z_right_bottom;
    assign ox[3] = hand_x_right_top;    assign oy[3] = hand_y_right_top;    assign oz[3] = hand_z_right_top;
    assign ox[4] = head_x;              assign oy[4] = head_y;              assign oz[4] = head_z;

    typedef struct {
        logic [4:0] mask;
        int         x0;
        int         w;
        int         y0;
        int         h;
        bit         fixed;    // every pixel at (x0,y0)
        bit         fe_same;  // frame_end with the last pixel
        int         ex;
        int         ey;
        int         ez;
        logic [4:0] elost;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         mx [5];
    int         my [5];
    int         mz [5];
    logic [4:0] mlost;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mx[i] = 0;
            my[i] = 0;
            mz[i] = 16383;
        end
        mlost = 5'b11111;
    endtask

    task automatic model_update(input vec_t v);
        for (int i = 0; i < 5; i++) begin
            if (!v.elost[i]) begin
                mx[i] = v.ex;
                my[i] = v.ey;
                mz[i] = v.ez;
            end
        end
        mlost = v.elost;
    endtask

    task automatic chk_coords(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(ox[i]), 32'(mx[i]));
            chk($sformatf("%s_y%0d", tag, i), 32'(oy[i]), 32'(my[i]));
            chk($sformatf("%s_z%0d", tag, i), 32'(oz[i]), 32'(mz[i]));
        end
        chk($sformatf("%s_lost", tag), 32'(lost_out), 32'(mlost));
    endtask

    task automatic idle_inputs();
        valid_in     = 1'b0;
        mask_in      = '0;
        hcount_in    = '0;
        vcount_in    = '0;
        frame_end_in = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, output int t_fe);
        int n;
        int k;
        n = v.w * v.h;
        k = 0;
        t_fe = -1;
        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                valid_in  = 1'b1;
                mask_in   = v.mask;
                hcount_in = 11'(v.fixed ? v.x0 : v.x0 + c);
                vcount_in = 10'(v.fixed ? v.y0 : v.y0 + r);
                k++;
                if (k == n && v.fe_same) begin
                    frame_end_in = 1'b1;
                    t_fe = cyc;
                end
                tick();
                idle_inputs();
            end
        end
        if (!v.fe_same) begin
            frame_end_in = 1'b1;
            t_fe = cyc;
            tick();
            idle_inputs();
        end
    endtask

    // Wait for the valid pulse, then check latency and every output
    task automatic wait_pub(input int t_fe, input string tag);
        int k;
        k = 0;
        while (coords_valid_out !== 1'b1 && k < 500) begin
            tick();
            k++;
        end
        chk($sformatf("%s_valid_seen", tag), 32'(coords_valid_out), 32'd1);
        chk($sformatf("%s_latency", tag), 32'(cyc - t_fe), 32'd331);
        chk($sformatf("%s_busy_pub", tag), 32'(busy_out), 32'd0);
        chk_coords(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_fe;
        int   t2;
        int   pulses;
        vec_t va;
        vec_t vb;
        vec_t vr;

        // mask, x0, w, y0, h, fixed, fe_same, ex, ey, ez, elost
        vecs[0] = '{5'b00001,  100, 10, 200, 10, 1'b0, 1'b0,  104, 204, 16377, 5'b11110};
        vecs[1] = '{5'b00001,   50, 10,  50,  1, 1'b0, 1'b0,    0,   0,     0, 5'b11111};
        vecs[2] = '{5'b10000, 1279,  5, 719,  5, 1'b1, 1'b1, 1279, 719, 16382, 5'b01111};
        vecs[3] = '{5'b11111,    0, 20,   0, 20, 1'b0, 1'b0,    9,   9, 16358, 5'b00000};
        vecs[4] = '{5'b00110, 1000, 16, 300,  2, 1'b0, 1'b0, 1007, 300, 16381, 5'b11001};
        vecs[5] = '{5'b01000,  640,  4, 360,  4, 1'b0, 1'b1,  641, 361, 16382, 5'b10111};
        vecs[6] = '{5'b01000,    0, 15,   0,  1, 1'b0, 1'b0,    0,   0,     0, 5'b11111};

        idle_inputs();
        rst_in = 1'b1;
        model_reset();
        repeat (3) tick();
        chk_coords("reset");
        chk("reset_valid", 32'(coords_valid_out), 32'd0);
        chk("reset_busy", 32'(busy_out), 32'd0);
        chk("reset_overrun", 32'(overrun_out), 32'd0);
        rst_in = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v], t_fe);
            chk($sformatf("v%0d_busy", v), 32'(busy_out), 32'd1);
            chk($sformatf("v%0d_overrun", v), 32'(overrun_out), 32'd0);
            model_update(vecs[v]);
            wait_pub(t_fe, $sformatf("v%0d", v));
            tick();
            chk($sformatf("v%0d_valid_drop", v), 32'(coords_valid_out), 32'd0);
            repeat (3) tick();
        end

        // Overrun: second frame_end 100 cycles after the first is dropped
        va = '{5'b00001, 200, 10, 100, 10, 1'b0, 1'b0, 204, 104, 16377, 5'b11110};
        run_frame(va, t_fe);
        chk("ovr_busy", 32'(busy_out), 32'd1);
        vb = '{5'b00001, 5, 99, 5, 1, 1'b1, 1'b0, 0, 0, 0, 5'b11110};
        run_frame(vb, t2);
        chk("ovr_gap", 32'(t2 - t_fe), 32'd100);
        chk("ovr_pulse", 32'(overrun_out), 32'd1);
        tick();
        chk("ovr_pulse_end", 32'(overrun_out), 32'd0);
        model_update(va);
        wait_pub(t_fe, "ovr");

        // frame_end in the PUBLISH cycle is an overrun, not a new frame
        frame_end_in = 1'b1;
        tick();
        idle_inputs();
        chk("pubfe_overrun", 32'(overrun_out), 32'd1);
        chk("pubfe_busy", 32'(busy_out), 32'd0);
        chk("pubfe_valid_drop", 32'(coords_valid_out), 32'd0);

        // frame_end right after PUBLISH is accepted (only 1 px -> all lost)
        valid_in     = 1'b1;
        mask_in      = 5'b00001;
        hcount_in    = 11'd7;
        vcount_in    = 10'd7;
        frame_end_in = 1'b1;
        t2 = cyc;
        tick();
        idle_inputs();
        chk("idlefe_busy", 32'(busy_out), 32'd1);
        chk("idlefe_overrun", 32'(overrun_out), 32'd0);
        mlost = 5'b11111;
        wait_pub(t2, "idlefe");
        tick();
        chk("idlefe_valid_drop", 32'(coords_valid_out), 32'd0);
        repeat (3) tick();

        // Reset during DIVIDE discards the frame
        vr = '{5'b00010, 20, 10, 30, 10, 1'b0, 1'b0, 24, 34, 16377, 5'b11101};
        run_frame(vr, t_fe);
        while (cyc < t_fe + 150) tick();
        chk("rstdiv_busy_before", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        #1;
        model_reset();
        chk_coords("rstdiv");
        chk("rstdiv_busy", 32'(busy_out), 32'd0);
        chk("rstdiv_valid", 32'(coords_valid_out), 32'd0);
        repeat (2) tick();
        rst_in = 1'b0;
        pulses = 0;
        repeat (400) begin
            tick();
            if (coords_valid_out === 1'b1) pulses++;
        end
        chk("rstdiv_no_pulse", 32'(pulses), 32'd0);

        run_frame(vr, t_fe);
        chk("post_rst_busy", 32'(busy_out), 32'd1);
        model_update(vr);
        wait_pub(t_fe, "post_rst");
        tick();
        chk("post_rst_valid_drop", 32'(coords_valid_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
